decode_execute_reg: RTL and testbench
=====================================

Name: decode_execute_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline. Sits between the decode stage and the execute stage.
- Captures decoded control, operands and register specifiers every cycle.
- Inserts a bubble when the hazard unit asserts flushe.
- Drives the execute-stage signals the hazard unit consumes: rse, rte, writerege, regwritee, memtorege.
- Keeps saturating bubble and issue counters for pipeline-efficiency measurement.

Parameters:
- DATA_W, 32, width of operand and immediate datapath.
- COUNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- validd  input  1  decode stage holds a real instruction.
- regwrited  input  1  decode control: register write.
- memtoregd  input  1  decode control: load result select.
- memwrited  input  1  decode control: store.
- alucontrold  input  3  decode ALU operation.
- alusrcd  input  1  decode control: immediate operand select.
- regdstd  input  1  decode control: destination is rd (1) or rt (0).
- rd1d  input  DATA_W  register-file read data A.
- rd2d  input  DATA_W  register-file read data B.
- signimmd  input  DATA_W  sign-extended immediate.
- rsd  input  5  decode rs specifier.
- rtd  input  5  decode rt specifier.
- rdd  input  5  decode rd specifier.
- flushe  input  1  from hazard unit: load a bubble this edge.
- cnt_clr  input  1  synchronous clear of both counters.
- valide  output  1  execute stage holds a real instruction.
- regwritee, memtorege, memwritee, alusrce, regdste  output  1 each  registered control.
- alucontrole  output  3  registered ALU operation.
- rd1e  output  DATA_W  registered operand A.
- rd2e  output  DATA_W  registered operand B.
- signimme  output  DATA_W  registered immediate.
- rse  output  5  registered rs.
- rte  output  5  registered rt.
- rde  output  5  registered rd.
- writerege  output  5  execute destination register.
- bubble_cnt  output  COUNT_W  count of bubbles inserted.
- issue_cnt  output  COUNT_W  count of valid instructions entering execute.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-operation):
  - every registered output is 0, including both counters.
  - writerege therefore reads 0.
  - The first capture happens on the first rising edge after rst_n deasserts.
- Latency: one cycle. A value presented on a d input before edge N appears on the matching e output after edge N.
- No enable: the hazard unit stalls only F and D, so this register captures every edge.
- Edge with flushe=1:
  - valide, regwritee, memtorege, memwritee, alusrce, regdste load 0.
  - alucontrole loads 3'b000.
  - rse, rte, rde load 5'd0.
  - rd1e, rd2e, signimme load 0.
  - Forcing rse/rte to 0 keeps the forwarding comparisons inactive.
- Edge with flushe=0: every field loads its d input. validd passes through to valide.
- writerege is combinational from registered state: regdste ? rde : rte.
  - Consequence: after a bubble, writerege=0 and regwritee=0.
- Counters, evaluated each edge in priority order:
  1. cnt_clr=1: both counters load 0. This overrides any increment in the same cycle.
  2. flushe=1: bubble_cnt increments.
  3. flushe=0 and validd=1: issue_cnt increments.
- The two increments are mutually exclusive in a cycle.
- Each counter saturates at all-ones (2^COUNT_W−1) and holds there; it never wraps.
- An edge with validd=0 and flushe=0 passes the invalid instruction through and changes neither counter.

Test Plan:
- Reset mid-stream: drive regwrited=1, rsd=5'd8 and clock; assert rst_n=0 between edges → all outputs 0 immediately, with no clock edge required.
- Normal capture: rd1d=32'h1234_5678, rsd=9, rtd=10, rdd=11, regdstd=1, regwrited=1, validd=1, one edge → rd1e=32'h1234_5678, rse=9, rte=10, writerege=11, issue_cnt=1.
- writerege mux: same capture with regdstd=0 → writerege=10.
- Load-use bubble: memtoregd=1, rtd=7 in cycle N, then flushe=1 in cycle N+1 → after edge N+1:
  - valide=0, regwritee=0, memtorege=0, rse=0, rte=0, writerege=0.
  - bubble_cnt=1, issue_cnt unchanged.
- Saturation with COUNT_W=4: 20 consecutive flushe=1 edges → bubble_cnt=4'hF after the 15th edge and it stays 4'hF.
- Clear priority: cnt_clr=1 together with flushe=1 → bubble_cnt=0 after the edge, and the execute fields still show a bubble.

Source files
------------

// File: rtl/decode_execute_reg.sv
// rtl/decode_execute_reg.sv - ID/EX pipeline register with bubble insertion and saturating counters
module decode_execute_reg #(
  parameter int DATA_W  = 32,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               validd,
  input  logic               regwrited,
  input  logic               memtoregd,
  input  logic               memwrited,
  input  logic [2:0]         alucontrold,
  input  logic               alusrcd,
  input  logic               regdstd,
  input  logic [DATA_W-1:0]  rd1d,
  input  logic [DATA_W-1:0]  rd2d,
  input  logic [DATA_W-1:0]  signimmd,
  input  logic [4:0]         rsd,
  input  logic [4:0]         rtd,
  input  logic [4:0]         rdd,
  input  logic               flushe,
  input  logic               cnt_clr,
  output logic               valide,
  output logic               regwritee,
  output logic               memtorege,
  output logic               memwritee,
  output logic               alusrce,
  output logic               regdste,
  output logic [2:0]         alucontrole,
  output logic [DATA_W-1:0]  rd1e,
  output logic [DATA_W-1:0]  rd2e,
  output logic [DATA_W-1:0]  signimme,
  output logic [4:0]         rse,
  output logic [4:0]         rte,
  output logic [4:0]         rde,
  output logic [4:0]         writerege,
  output logic [COUNT_W-1:0] bubble_cnt,
  output logic [COUNT_W-1:0] issue_cnt
);

  // Capture decode fields every edge; a flush loads an all-zero bubble so
  // the zeroed rs/rt never match a forwarding comparison downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flushe) begin
      valide      <= 1'b0;
      regwritee   <= 1'b0;
      memtorege   <= 1'b0;
      memwritee   <= 1'b0;
      alusrce     <= 1'b0;
      regdste     <= 1'b0;
      alucontrole <= 3'b000;
      rd1e        <= '0;
      rd2e        <= '0;
      signimme    <= '0;
      rse         <= 5'd0;
      rte         <= 5'd0;
      rde         <= 5'd0;
    end else begin
      valide      <= validd;
      regwritee   <= regwrited;
      memtorege   <= memtoregd;
      memwritee   <= memwrited;
      alusrce     <= alusrcd;
      regdste     <= regdstd;
      alucontrole <= alucontrold;
      rd1e        <= rd1d;
      rd2e        <= rd2d;
      signimme    <= signimmd;
      rse         <= rsd;
      rte         <= rtd;
      rde         <= rdd;
    end
  end

  // Destination register select from registered state; a bubble yields 0.
  always_comb begin
    writerege = regdste ? rde : rte;
  end

  // Saturating performance counters; clear beats both increments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      issue_cnt  <= '0;
    end else if (cnt_clr) begin
      bubble_cnt <= '0;
      issue_cnt  <= '0;
    end else if (flushe) begin
      if (bubble_cnt != {COUNT_W{1'b1}}) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end else if (validd) begin
      if (issue_cnt != {COUNT_W{1'b1}}) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decode_execute_reg.sv
// tb/tb_decode_execute_reg.sv - scoreboard bench for decode_execute_reg
module tb_decode_execute_reg;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic        alusrc;
    logic        regdst;
    logic [2:0]  aluctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } in_t;

  typedef struct {
    string      name;
    in_t        f;
    logic [4:0] wr;
    logic [3:0] bc;
    logic [3:0] ic;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        validd, regwrited, memtoregd, memwrited, alusrcd, regdstd;
  logic [2:0]  alucontrold;
  logic [31:0] rd1d, rd2d, signimmd;
  logic [4:0]  rsd, rtd, rdd;
  logic        flushe, cnt_clr;
  logic        valide, regwritee, memtorege, memwritee, alusrce, regdste;
  logic [2:0]  alucontrole;
  logic [31:0] rd1e, rd2e, signimme;
  logic [4:0]  rse, rte, rde, writerege;
  logic [3:0]  bubble_cnt, issue_cnt;

  in_t  got;
  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  decode_execute_reg #(.DATA_W(32), .COUNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .validd(validd), .regwrited(regwrited),
    .memtoregd(memtoregd), .memwrited(memwrited), .alucontrold(alucontrold),
    .alusrcd(alusrcd), .regdstd(regdstd), .rd1d(rd1d), .rd2d(rd2d),
    .signimmd(signimmd), .rsd(rsd), .rtd(rtd), .rdd(rdd), .flushe(flushe),
    .cnt_clr(cnt_clr), .valide(valide), .regwritee(regwritee),
    .memtorege(memtorege), .memwritee(memwritee), .alusrce(alusrce),
    .regdste(regdste), .alucontrole(alucontrole), .rd1e(rd1e), .rd2e(rd2e),
    .signimme(signimme), .rse(rse), .rte(rte), .rde(rde),
    .writerege(writerege), .bubble_cnt(bubble_cnt), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  assign got = {valide, regwritee, memtorege, memwritee, alusrce, regdste,
                alucontrole, rd1e, rd2e, signimme, rse, rte, rde};

  task automatic drive(input in_t d, input logic fl, input logic clr);
    validd = d.valid; regwrited = d.regwrite; memtoregd = d.memtoreg;
    memwrited = d.memwrite; alusrcd = d.alusrc; regdstd = d.regdst;
    alucontrold = d.aluctrl; rd1d = d.rd1; rd2d = d.rd2; signimmd = d.imm;
    rsd = d.rs; rtd = d.rt; rdd = d.rd; flushe = fl; cnt_clr = clr;
  endtask

  task automatic step(input string name, input in_t d, input logic fl, input logic clr,
                      input logic [4:0] wr, input logic [3:0] bc, input logic [3:0] ic);
    exp_t e;
    @(negedge clk);
    drive(d, fl, clr);
    e.name = name;
    e.f    = fl ? in_t'(0) : d;
    e.wr   = wr;
    e.bc   = bc;
    e.ic   = ic;
    q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    total += 4;
    if (got !== '0) begin
      bad++; $display("FAIL %s fields got=%h exp=0", name, got);
    end
    if (writerege !== 5'd0) begin
      bad++; $display("FAIL %s writerege got=%0d exp=0", name, writerege);
    end
    if (bubble_cnt !== 4'd0) begin
      bad++; $display("FAIL %s bubble_cnt got=%0d exp=0", name, bubble_cnt);
    end
    if (issue_cnt !== 4'd0) begin
      bad++; $display("FAIL %s issue_cnt got=%0d exp=0", name, issue_cnt);
    end
  endtask

  // Monitor: the register presents a new result after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        total += 3;
        if (got !== e.f) begin
          bad++; $display("FAIL %s fields got=%h exp=%h", e.name, got, e.f);
        end
        if (writerege !== e.wr) begin
          bad++; $display("FAIL %s writerege got=%0d exp=%0d", e.name, writerege, e.wr);
        end
        if (bubble_cnt !== e.bc || issue_cnt !== e.ic) begin
          bad++;
          $display("FAIL %s counters got bubble=%0d issue=%0d exp bubble=%0d issue=%0d",
                   e.name, bubble_cnt, issue_cnt, e.bc, e.ic);
        end
      end
    end
  end

  initial begin
    in_t v;
    rst_n = 1'b0;
    drive(in_t'(0), 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    v = '0; v.valid = 1; v.regwrite = 1; v.regdst = 1; v.alusrc = 1; v.aluctrl = 3'b010;
    v.rd1 = 32'h1234_5678; v.rd2 = 32'hCAFE_0001; v.imm = 32'hFFFF_FFF0;
    v.rs = 5'd9; v.rt = 5'd10; v.rd = 5'd11;
    step("capture_rd", v, 0, 0, 5'd11, 4'd0, 4'd1);
    v.regdst = 0;
    step("capture_rt", v, 0, 0, 5'd10, 4'd0, 4'd2);

    v = '0; v.valid = 1; v.regwrite = 1; v.memtoreg = 1; v.rs = 5'd4; v.rt = 5'd7;
    v.rd1 = 32'h0000_1000; v.imm = 32'h0000_0008;
    step("load", v, 0, 0, 5'd7, 4'd0, 4'd3);
    v.memtoreg = 0; v.rs = 5'd7; v.rt = 5'd2;
    step("load_use_bubble", v, 1, 0, 5'd0, 4'd1, 4'd3);

    v = '0; v.regdst = 1; v.memwrite = 1; v.rt = 5'd6; v.rd = 5'd5; v.rd2 = 32'hA5A5_A5A5;
    step("invalid_pass", v, 0, 0, 5'd5, 4'd1, 4'd3);

    v = '0; v.valid = 1; v.regwrite = 1; v.rt = 5'd12; v.rd1 = 32'h8000_0000;
    step("clr_over_issue", v, 0, 1, 5'd12, 4'd0, 4'd0);
    step("issue_after_clr", v, 0, 0, 5'd12, 4'd0, 4'd1);
    step("clr_over_bubble", v, 1, 1, 5'd0, 4'd0, 4'd0);

    for (int k = 1; k <= 20; k++)
      step("bubble_sat", v, 1, 0, 5'd0, (k > 15) ? 4'd15 : 4'(k), 4'd0);

    v = '0; v.valid = 1; v.rt = 5'd3; v.rd2 = 32'h0000_0033;
    for (int k = 1; k <= 17; k++)
      step("issue_sat", v, 0, 0, 5'd3, 4'd15, (k > 15) ? 4'd15 : 4'(k));

    v = '0; v.valid = 1; v.regwrite = 1; v.rs = 5'd8;
    step("pre_reset", v, 0, 0, 5'd0, 4'd15, 4'd15);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    drive(in_t'(0), 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    v = '0; v.valid = 1; v.regwrite = 1; v.regdst = 1; v.rs = 5'd1; v.rt = 5'd2; v.rd = 5'd31;
    v.rd1 = 32'hDEAD_BEEF;
    step("post_reset", v, 0, 0, 5'd31, 4'd0, 4'd1);

    @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL drain pending got=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
